// File: rtl/row_conv_stream_pkg.sv
// Shared types and helpers for the streaming row convolver.
// Pixel format and kernel depth are fixed here; lanes and frame geometry are top parameters.
package row_conv_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int K      = 8;
  localparam int KA_W   = $clog2(K);
  localparam int ACC_W  = 2*DATA_W + $clog2(K);

  typedef logic signed [DATA_W-1:0]   pix_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam acc_t SAT_HI = acc_t'(2**(DATA_W-1) - 1);
  localparam acc_t SAT_LO = ~SAT_HI;

  // Round half up, arithmetic shift back to Q format, clamp to pixel range.
  function automatic pix_t sat_round(acc_t a, int frac);
    acc_t r;
    r = (a + (acc_t'(1) <<< (frac - 1))) >>> frac;
    if (r > SAT_HI) return pix_t'(SAT_HI);
    if (r < SAT_LO) return pix_t'(SAT_LO);
    return pix_t'(r);
  endfunction

endpackage

// File: rtl/row_conv_stream_if.sv
// Column-in / result-out valid-ready streams of the row convolver.
// slave is the convolver side, master the loader/consumer side.
interface row_conv_stream_if
  import row_conv_pkg::*;
#(
  parameter int LANES = 28,
  parameter int IDX_W = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_col;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_col;
  logic [IDX_W-1:0]        out_idx;

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_col, out_idx
  );

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_col, out_idx
  );

endinterface

// File: rtl/row_conv_stream_lane.sv
// One image row: K-deep window, registered products, then sum/round/saturate/ReLU.
// Products are taken from the post-shift window so the firing beat is included.
module row_lane
  import row_conv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic fire,
  input  logic stall,
  input  pix_t pix_in,
  input  pix_t kernel [K],
  input  logic relu_en,
  output pix_t res
);

  pix_t  sr_q   [K];
  pix_t  win    [K];
  prod_t prod_q [K];
  acc_t  sum;
  pix_t  sat;
  logic  v_q;
  pix_t  res_q;

  always_comb begin
    for (int i = 0; i < K-1; i++) win[i] = sr_q[i+1];
    win[K-1] = pix_in;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < K; i++) sum = sum + acc_t'(prod_q[i]);
  end

  assign sat = sat_round(sum, FRAC_W);
  assign res = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        sr_q[i]   <= '0;
        prod_q[i] <= '0;
      end
      v_q   <= 1'b0;
      res_q <= '0;
    end else begin
      if (shift_en) begin
        for (int i = 0; i < K; i++) sr_q[i] <= win[i];
      end
      if (!stall) begin
        v_q <= fire;
        if (fire) begin
          for (int i = 0; i < K; i++)
            prod_q[i] <= prod_t'(win[i]) * prod_t'(kernel[i]);
        end
        if (v_q) res_q <= (relu_en && sat < 0) ? '0 : sat;
      end
    end
  end

endmodule

// File: rtl/row_conv_stream.sv
// Streaming strided row convolver: LANES rows in parallel, shared loadable kernel.
// Owns the frame FSM, column/phase/index counters and both handshakes.
module row_conv_stream
  import row_conv_pkg::*;
#(
  parameter int IN_LEN = 28,
  parameter int STRIDE = 2,
  parameter int LANES  = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            relu_en,
  input  logic            w_we,
  input  logic [KA_W-1:0] w_addr,
  input  pix_t            w_data,
  row_conv_stream_if.slave io,
  output logic            busy,
  output logic            done
);

  localparam int OUT_W = (IN_LEN - K) / STRIDE + 1;
  localparam int CW    = $clog2(IN_LEN);
  localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IN_LEN - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);
  localparam logic [OW-1:0] IDX_LAST  = OW'(OUT_W - 1);

  if (K > IN_LEN || ((IN_LEN - K) % STRIDE) != 0) begin : g_bad_cfg
    $error("row_conv_stream: K/IN_LEN/STRIDE do not tile a frame");
  end

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [PW-1:0] ph_q;
  logic [OW-1:0] idx_q;
  logic          v1_q, ov_q, relu_q, busy_q, done_q;
  pix_t          kern_q [K];

  logic stall, in_rdy, acc, win_ok, fire, hand;

  assign stall  = ov_q && !io.out_ready;
  assign in_rdy = (state_q == RUN) && !stall;
  assign acc    = io.in_valid && in_rdy;
  assign win_ok = col_q >= COL_FIRST;
  assign fire   = acc && win_ok && (ph_q == '0);
  assign hand   = ov_q && io.out_ready;

  assign io.in_ready  = in_rdy;
  assign io.out_valid = ov_q;
  assign io.out_idx   = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      v1_q    <= 1'b0;
      ov_q    <= 1'b0;
      relu_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < K; i++) kern_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (!stall) begin
        v1_q <= fire;
        ov_q <= v1_q;
      end
      if (hand) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (acc) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        if (win_ok) ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          // A same-cycle tap write still lands before the first beat.
          if (w_we) kern_q[w_addr] <= w_data;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            relu_q  <= relu_en;
            col_q   <= '0;
            ph_q    <= '0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (acc && col_q == COL_LAST) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!v1_q && !ov_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pix_t res;
    row_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (acc),
      .fire     (fire),
      .stall    (stall),
      .pix_in   (io.in_col[l*DATA_W +: DATA_W]),
      .kernel   (kern_q),
      .relu_en  (relu_q),
      .res      (res)
    );
    assign io.out_col[l*DATA_W +: DATA_W] = res;
  end

endmodule

// File: tb/tb_row_conv_stream.sv
// Bench for row_conv_stream: frame-level stimulus against a direct
// sum-of-products reference computed per output column.
module tb_row_conv_stream;
  import row_conv_pkg::*;

  localparam int IN_LEN = 28;
  localparam int STRIDE = 2;
  localparam int LANES  = 28;
  localparam int OUT_W  = (IN_LEN - K) / STRIDE + 1;
  localparam int IW     = $clog2(OUT_W);

  logic            clk = 1'b0;
  logic            rst, start, relu_en, w_we;
  logic [KA_W-1:0] w_addr;
  logic [15:0]     w_data;
  logic            busy, done;

  row_conv_stream_if #(.LANES(LANES), .IDX_W(IW)) io ();

  row_conv_stream #(
    .IN_LEN (IN_LEN),
    .STRIDE (STRIDE),
    .LANES  (LANES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .relu_en (relu_en),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .io      (io),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic signed [15:0] px [LANES][IN_LEN];
  logic signed [15:0] kw [K];
  bit                 relu_m;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_out(int l, int j);
    longint s = 0;
    for (int k = 0; k < K; k++)
      s += longint'(px[l][j*STRIDE + k]) * longint'(kw[k]);
    s = (s + 128) >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu_m && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic fill_px(input int pat);
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < IN_LEN; c++)
        case (pat)
          0: px[l][c] = 16'((l + 1) << 8);
          1: px[l][c] = 16'(c << 8);
          2: px[l][c] = 16'h7fff;
          default: px[l][c] = 16'($urandom);
        endcase
  endtask

  task automatic fill_kw(input logic [15:0] v);
    for (int k = 0; k < K; k++) kw[k] = v;
  endtask

  // Last tap is written together with start inside frame().
  task automatic load_kern();
    for (int i = 0; i < K-1; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = KA_W'(i); w_data = kw[i];
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic frame(input bit relu, input int rdy_pct,
                       input int abort_at, input bit poke);
    int sent, got, cyc;
    bit fin;
    @(negedge clk);
    start = 1'b1; relu_en = relu;
    w_we = 1'b1; w_addr = KA_W'(K-1); w_data = kw[K-1];
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; relu_en = ~relu; w_we = 1'b0;
    relu_m = relu;
    sent = 0; got = 0; cyc = 0; fin = 0;
    while (cyc < 600 && !fin) begin
      if (cyc > 0) @(negedge clk);
      start = poke && cyc == 4;
      w_we  = poke && cyc == 4;
      w_addr = '0; w_data = 16'h1234;
      io.in_valid = sent < IN_LEN;
      for (int l = 0; l < LANES; l++)
        io.in_col[l*16 +: 16] = px[l][(sent < IN_LEN) ? sent : 0];
      io.out_ready = $urandom_range(99) < rdy_pct;
      #1;
      if (cyc == 0) check("run_busy", busy, 1);
      check("in_ready", io.in_ready,
            (sent < IN_LEN) && !(io.out_valid && !io.out_ready));
      if (io.out_valid && io.out_ready) begin
        if (got < OUT_W) begin
          check($sformatf("idx%0d", got), io.out_idx, got);
          for (int l = 0; l < LANES; l++)
            check($sformatf("l%0d_j%0d", l, got),
                  io.out_col[l*16 +: 16], ref_out(l, got));
        end else begin
          check("extra_beat", got, OUT_W - 1);
        end
        got++;
      end
      if (io.in_valid && io.in_ready) sent++;
      if (done) begin
        fin = 1;
        check("beats", got, OUT_W);
        check("all_in", sent, IN_LEN);
      end
      if (abort_at >= 0 && sent == abort_at) fin = 1;
      cyc++;
    end
    if (!fin) check("timeout", 0, 1);
    start = 1'b0; w_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; w_we = 1'b0;
    w_addr = '0; w_data = '0;
    io.in_valid = 1'b0; io.in_col = '0; io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", io.in_ready, 0);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_col", io.out_col == '0, 1);
    check("rst_out_idx", io.out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    fill_px(0); fill_kw(16'h0100); load_kern();
    frame(0, 100, -1, 0);

    fill_px(1); fill_kw(16'h0000); kw[0] = 16'h0100; load_kern();
    frame(0, 100, -1, 0);

    fill_px(2); fill_kw(16'h7fff); load_kern();
    frame(0, 100, -1, 0);
    fill_kw(16'h8001); load_kern();
    frame(0, 100, -1, 0);
    frame(1, 100, -1, 0);

    fill_px(3);
    for (int k = 0; k < K; k++)
      kw[k] = 16'(int'($urandom_range(1023)) - 512);
    load_kern();
    frame(0, 50, -1, 0);
    frame(1, 50, -1, 0);
    frame(0, 100, -1, 0);

    fill_px(0); fill_kw(16'h0100); load_kern();
    frame(0, 100, 15, 0);
    @(negedge clk);
    io.in_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", io.out_valid, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 check("abort_no_done", done, 0);
    end
    fill_kw(16'h0000);
    frame(0, 100, -1, 0);
    fill_kw(16'h0100); load_kern();
    frame(0, 100, -1, 0);

    fill_px(3);
    frame(0, 70, -1, 1);
    frame(0, 100, -1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
